dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Sits directly downstream of the DRAM-init block and the other FTL DRAM clients (L2P lookup, GC, cache manager), and upstream of the DRAM controller user interface.
- Grants exclusive DRAM ownership to one requester at a time using a request/permit/release handshake, with round-robin fairness.
- Muxes the owner's command, write-data and mask onto the controller, and routes ready/valid strobes back to the owner only.
- Drains outstanding read beats before handing ownership to the next port.

Parameters:
- NUM_PORTS, 4, number of requesters; port 0 is the init block.
- PORT_IDX_WIDTH, 2, clog2(NUM_PORTS).
- DRAM_ADDR_WIDTH, 29, DRAM command address width.
- DRAM_IO_WIDTH, 256, DRAM data width.
- DRAM_MASK_WIDTH, 32, byte-mask width.
- BEATS_PER_READ, 2, rd_data_valid beats returned per accepted read command.
- READ_CMD, 1'b1, value of rd_wr that denotes a read; the other value is a write.

Ports:
- clk  in  1  clock
- reset  in  1  async active-low reset
- req_i  in  NUM_PORTS  per-port ownership request, level
- release_i  in  NUM_PORTS  per-port release pulse
- permit_o  out  NUM_PORTS  one-hot ownership; high for the whole tenure
- en_i  in  NUM_PORTS  per-port command enable
- rd_wr_i  in  NUM_PORTS  per-port read/write select
- addr_i  in  NUM_PORTS*DRAM_ADDR_WIDTH  flattened, port 0 in the LSBs
- wdata_i  in  NUM_PORTS*DRAM_IO_WIDTH  flattened write data
- mask_i  in  NUM_PORTS*DRAM_MASK_WIDTH  flattened byte masks
- wdata_en_i  in  NUM_PORTS  write-data enable
- wdata_end_i  in  NUM_PORTS  write-data end-of-burst
- cmd_ready_o  out  NUM_PORTS  controller ready, owner only
- wdata_ready_o  out  NUM_PORTS  write-data ready, owner only
- rd_valid_o  out  NUM_PORTS  read-data valid, read owner only
- rdata_o  out  DRAM_IO_WIDTH  read data, broadcast to all ports
- dram_en_o, dram_rd_wr_o, dram_addr_o, dram_wdata_o, dram_mask_o, dram_wdata_en_o, dram_wdata_end_o  out  to controller
- dram_ready_i, dram_wdata_ready_i, dram_rd_valid_i, dram_rdata_i  in  from controller

Behaviour:
- Reset (async, active-low): state IDLE, owner=0, rr_ptr=0, beat_cnt=0. All outputs 0.
- IDLE:
  - If any req_i bit is high, pick the first requesting port at or after rr_ptr (modulo NUM_PORTS) and go to OWNED.
  - permit_o for the chosen port rises the cycle after the request is seen (1-cycle grant latency).
- OWNED: permit_o[owner]=1.
  - Controller outputs are driven combinationally from the owner's inputs.
  - dram_ready_i, dram_wdata_ready_i and dram_rd_valid_i are forwarded to the owner's bit only; all other bits are 0.
  - Non-owner en_i and wdata_en_i are ignored and never reach the controller.
- release_i[owner]=1: go to DRAIN. permit_o drops the next cycle. Set rr_ptr=owner+1 (mod NUM_PORTS). Hold rd_owner=owner.
- Release from a non-owner: ignored. A release pulse in the same cycle as the grant is also ignored.
- DRAIN:
  - Controller outputs are 0 except read return; rd_valid_o is routed to rd_owner.
  - When beat_cnt==0, go to GAP.
  - Enter DRAIN even if beat_cnt is already 0; minimum 1 cycle.
- GAP: one idle cycle, then IDLE. Minimum handover is 3 cycles from release to the next permit.
- beat_cnt: accepted read = dram_en_o & dram_ready_i & (dram_rd_wr_o==READ_CMD).
  - Accepted read adds BEATS_PER_READ; each dram_rd_valid_i subtracts 1.
  - Both in the same cycle: net change is +BEATS_PER_READ-1.
  - Width is 8 bits and saturates at max.
  - rd_valid_i while beat_cnt==0 is an underflow: hold at 0 and still route to rd_owner.
- A request held by the current owner after release does not keep ownership. Round-robin still applies; the port regains ownership only if no other port requests.
- Reset mid-tenure or mid-drain: immediate return to IDLE. Outstanding beats are discarded and permit drops asynchronously.

Decomposition:
- Shared package ftl_define:
  - DRAM_ADDR_WIDTH, DRAM_IO_WIDTH, DRAM_MASK_WIDTH.
  - Arbiter state encoding (IDLE=2'b00, OWNED=2'b01, DRAIN=2'b10, GAP=2'b11).
  - READ_CMD.
- Sub-module rr_picker (combinational): inputs req, rr_ptr; outputs grant_idx, any_req.

Test Plan:
- Single requester: req_i=4'b0001 at cycle 0 -> permit_o=4'b0001 at cycle 1. An en_i[0] read at addr 0x10 appears on dram_addr_o=0x10. cmd_ready_o[0] mirrors dram_ready_i.
- Round-robin: req_i=4'b1011 held, each owner releases after 1 command -> grant order 0,1,3,0.
- Drain: port 1 issues 3 reads, then releases before any data returns -> state stays DRAIN until 6 rd_valid beats arrive. All 6 go to rd_valid_o[1]. permit for port 2 comes 2 cycles after the 6th beat.
- Isolation: port 2 asserts en_i and wdata_en_i while port 0 owns -> dram_en_o follows port 0 only; wdata_ready_o[2] stays 0.
- Simultaneous read accept and rd_valid on the same cycle with beat_cnt=1 -> beat_cnt becomes 2.
- Reset asserted mid-OWNED with beat_cnt=4 -> all outputs 0 immediately. After reset release and req_i=4'b0100 -> permit_o=4'b0100 one cycle later.

Source files
------------

// File: rtl/ftl_define.sv
// Shared FTL DRAM definitions: bus widths, command encoding and arbiter state.
package ftl_define;

  localparam int DRAM_ADDR_WIDTH = 29;
  localparam int DRAM_IO_WIDTH   = 256;
  localparam int DRAM_MASK_WIDTH = 32;
  localparam int BEAT_CNT_WIDTH  = 8;

  // rd_wr value that denotes a read; any other value is a write
  localparam logic READ_CMD = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWNED = 2'b01,
    DRAIN = 2'b10,
    GAP   = 2'b11
  } arb_state_t;

endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// Round-robin picker: first requesting port at or after rr_ptr, wrapping.
module rr_picker #(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_IDX_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0]      req,
  input  logic [PORT_IDX_WIDTH-1:0] rr_ptr,
  output logic [PORT_IDX_WIDTH-1:0] grant_idx,
  output logic                      any_req
);

  // Scan from the farthest candidate back to rr_ptr so the nearest requester wins
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % NUM_PORTS]) begin
        grant_idx = PORT_IDX_WIDTH'((int'(rr_ptr) + i) % NUM_PORTS);
        any_req   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// DRAM ownership arbiter: request/permit/release handshake with round-robin
// fairness, owner-only command muxing, and read-beat draining before handover.
module dram_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int PORT_IDX_WIDTH  = 2,
  parameter int DRAM_ADDR_WIDTH = ftl_define::DRAM_ADDR_WIDTH,
  parameter int DRAM_IO_WIDTH   = ftl_define::DRAM_IO_WIDTH,
  parameter int DRAM_MASK_WIDTH = ftl_define::DRAM_MASK_WIDTH,
  parameter int BEATS_PER_READ  = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 req_i,
  input  logic [NUM_PORTS-1:0]                 release_i,
  output logic [NUM_PORTS-1:0]                 permit_o,
  input  logic [NUM_PORTS-1:0]                 en_i,
  input  logic [NUM_PORTS-1:0]                 rd_wr_i,
  input  logic [NUM_PORTS*DRAM_ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*DRAM_IO_WIDTH-1:0]   wdata_i,
  input  logic [NUM_PORTS*DRAM_MASK_WIDTH-1:0] mask_i,
  input  logic [NUM_PORTS-1:0]                 wdata_en_i,
  input  logic [NUM_PORTS-1:0]                 wdata_end_i,
  output logic [NUM_PORTS-1:0]                 cmd_ready_o,
  output logic [NUM_PORTS-1:0]                 wdata_ready_o,
  output logic [NUM_PORTS-1:0]                 rd_valid_o,
  output logic [DRAM_IO_WIDTH-1:0]             rdata_o,
  output logic                                 dram_en_o,
  output logic                                 dram_rd_wr_o,
  output logic [DRAM_ADDR_WIDTH-1:0]           dram_addr_o,
  output logic [DRAM_IO_WIDTH-1:0]             dram_wdata_o,
  output logic [DRAM_MASK_WIDTH-1:0]           dram_mask_o,
  output logic                                 dram_wdata_en_o,
  output logic                                 dram_wdata_end_o,
  input  logic                                 dram_ready_i,
  input  logic                                 dram_wdata_ready_i,
  input  logic                                 dram_rd_valid_i,
  input  logic [DRAM_IO_WIDTH-1:0]             dram_rdata_i
);
  import ftl_define::*;

  localparam int CNT_W = BEAT_CNT_WIDTH;

  arb_state_t                state, state_next;
  logic [PORT_IDX_WIDTH-1:0] owner, owner_next;
  logic [PORT_IDX_WIDTH-1:0] rd_owner, rd_owner_next;
  logic [PORT_IDX_WIDTH-1:0] rr_ptr, rr_ptr_next;
  logic [PORT_IDX_WIDTH-1:0] grant_idx;
  logic                      any_req;
  logic [CNT_W-1:0]          beat_cnt, beat_cnt_next;
  logic                      rd_accept;

  // Outstanding-beat update: add a full burst per accepted read, retire one
  // per returned beat, never wrap below zero or above the counter maximum.
  function automatic logic [CNT_W-1:0] next_beat_cnt(input logic [CNT_W-1:0] cnt,
                                                     input logic accept,
                                                     input logic beat);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (accept ? (CNT_W+1)'(BEATS_PER_READ) : '0);
    if (beat && sum != '0) sum = sum - 1'b1;
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Port after p, wrapping to 0
  function automatic logic [PORT_IDX_WIDTH-1:0] next_port(input logic [PORT_IDX_WIDTH-1:0] p);
    return (p == PORT_IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : p + PORT_IDX_WIDTH'(1);
  endfunction

  rr_picker #(
    .NUM_PORTS     (NUM_PORTS),
    .PORT_IDX_WIDTH(PORT_IDX_WIDTH)
  ) u_picker (
    .req      (req_i),
    .rr_ptr   (rr_ptr),
    .grant_idx(grant_idx),
    .any_req  (any_req)
  );

  assign rd_accept     = dram_en_o & dram_ready_i & (dram_rd_wr_o == READ_CMD);
  assign beat_cnt_next = next_beat_cnt(beat_cnt, rd_accept, dram_rd_valid_i);
  assign rdata_o       = dram_rdata_i;

  // State and bookkeeping registers; reset abandons any tenure and outstanding beats
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      rd_owner <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      rd_owner <= rd_owner_next;
      rr_ptr   <= rr_ptr_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  // Next-state: GAP is the idle handover cycle in which the next owner is chosen
  always_comb begin
    state_next    = state;
    owner_next    = owner;
    rd_owner_next = rd_owner;
    rr_ptr_next   = rr_ptr;
    case (state)
      IDLE, GAP: begin
        if (any_req) begin
          state_next = OWNED;
          owner_next = grant_idx;
        end else begin
          state_next = IDLE;
        end
      end
      OWNED: begin
        if (release_i[owner]) begin
          state_next    = DRAIN;
          rd_owner_next = owner;
          rr_ptr_next   = next_port(owner);
        end
      end
      DRAIN: begin
        if (beat_cnt_next == '0) state_next = GAP;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output mux: only the owner reaches the controller; read returns follow rd_owner after release
  always_comb begin
    permit_o         = '0;
    cmd_ready_o      = '0;
    wdata_ready_o    = '0;
    rd_valid_o       = '0;
    dram_en_o        = 1'b0;
    dram_rd_wr_o     = 1'b0;
    dram_addr_o      = '0;
    dram_wdata_o     = '0;
    dram_mask_o      = '0;
    dram_wdata_en_o  = 1'b0;
    dram_wdata_end_o = 1'b0;
    if (state == OWNED) begin
      permit_o[owner]      = 1'b1;
      dram_en_o            = en_i[owner];
      dram_rd_wr_o         = rd_wr_i[owner];
      dram_addr_o          = addr_i[int'(owner)*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
      dram_wdata_o         = wdata_i[int'(owner)*DRAM_IO_WIDTH +: DRAM_IO_WIDTH];
      dram_mask_o          = mask_i[int'(owner)*DRAM_MASK_WIDTH +: DRAM_MASK_WIDTH];
      dram_wdata_en_o      = wdata_en_i[owner];
      dram_wdata_end_o     = wdata_end_i[owner];
      cmd_ready_o[owner]   = dram_ready_i;
      wdata_ready_o[owner] = dram_wdata_ready_i;
      rd_valid_o[owner]    = dram_rd_valid_i;
    end else begin
      rd_valid_o[rd_owner] = dram_rd_valid_i;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: per-cycle vector tables with a scoreboard queue,
// plus hand-written reset sequences.
module tb_dram_arbiter;

  localparam int NP = 4;
  localparam int AW = 29;
  localparam int DW = 256;
  localparam int MW = 32;
  localparam logic [AW-1:0] A0 = 29'h010;
  localparam logic [AW-1:0] A1 = 29'h110;
  localparam logic [AW-1:0] A2 = 29'h210;
  localparam logic [AW-1:0] A3 = 29'h310;

  logic clk, reset;
  logic [NP-1:0] req_i, release_i, permit_o, en_i, rd_wr_i, wdata_en_i, wdata_end_i;
  logic [NP-1:0] cmd_ready_o, wdata_ready_o, rd_valid_o;
  logic [NP*AW-1:0] addr_i;
  logic [NP*DW-1:0] wdata_i;
  logic [NP*MW-1:0] mask_i;
  logic [DW-1:0] rdata_o, dram_wdata_o, dram_rdata_i;
  logic dram_en_o, dram_rd_wr_o, dram_wdata_en_o, dram_wdata_end_o;
  logic [AW-1:0] dram_addr_o;
  logic [MW-1:0] dram_mask_o;
  logic dram_ready_i, dram_wdata_ready_i, dram_rd_valid_i;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] req, rel, en, rdwr, wen;
    logic rdy, wrdy, rv;
    logic [3:0] e_permit;
    logic e_en, e_wen;
    logic [AW-1:0] e_addr;
    logic [3:0] e_cmdrdy, e_wrdy, e_rv;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  dram_arbiter dut (
    .clk(clk), .reset(reset), .req_i(req_i), .release_i(release_i), .permit_o(permit_o),
    .en_i(en_i), .rd_wr_i(rd_wr_i), .addr_i(addr_i), .wdata_i(wdata_i), .mask_i(mask_i),
    .wdata_en_i(wdata_en_i), .wdata_end_i(wdata_end_i), .cmd_ready_o(cmd_ready_o),
    .wdata_ready_o(wdata_ready_o), .rd_valid_o(rd_valid_o), .rdata_o(rdata_o),
    .dram_en_o(dram_en_o), .dram_rd_wr_o(dram_rd_wr_o), .dram_addr_o(dram_addr_o),
    .dram_wdata_o(dram_wdata_o), .dram_mask_o(dram_mask_o), .dram_wdata_en_o(dram_wdata_en_o),
    .dram_wdata_end_o(dram_wdata_end_o), .dram_ready_i(dram_ready_i),
    .dram_wdata_ready_i(dram_wdata_ready_i), .dram_rd_valid_i(dram_rd_valid_i),
    .dram_rdata_i(dram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(input logic [3:0] req, rel, en, rdwr, wen,
                             input logic rdy, wrdy, rv,
                             input logic [3:0] e_permit, input logic e_en, e_wen,
                             input logic [AW-1:0] e_addr, input logic [3:0] e_cmdrdy, e_wrdy, e_rv);
    vec_t t;
    t.req = req; t.rel = rel; t.en = en; t.rdwr = rdwr; t.wen = wen;
    t.rdy = rdy; t.wrdy = wrdy; t.rv = rv;
    t.e_permit = e_permit; t.e_en = e_en; t.e_wen = e_wen; t.e_addr = e_addr;
    t.e_cmdrdy = e_cmdrdy; t.e_wrdy = e_wrdy; t.e_rv = e_rv;
    return t;
  endfunction

  // idle cycle expecting every output at 0
  function automatic vec_t vz(input logic [3:0] req);
    return v(req, 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, '0, 4'b0, 4'b0, 4'b0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    req_i = '0; release_i = '0; en_i = '0; rd_wr_i = '0; wdata_en_i = '0; wdata_end_i = '0;
    dram_ready_i = 1'b0; dram_wdata_ready_i = 1'b0; dram_rd_valid_i = 1'b0; dram_rdata_i = '0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".permit"}, 64'(permit_o), 64'd0);
    chk({name, ".dram_en"}, 64'(dram_en_o), 64'd0);
    chk({name, ".dram_addr"}, 64'(dram_addr_o), 64'd0);
    chk({name, ".cmd_ready"}, 64'(cmd_ready_o), 64'd0);
    chk({name, ".wdata_ready"}, 64'(wdata_ready_o), 64'd0);
    chk({name, ".rd_valid"}, 64'(rd_valid_o), 64'd0);
  endtask

  // One cycle: drive after the rising edge, queue the expectation, compare at the falling edge
  task automatic step(input vec_t t, input string name);
    vec_t e;
    req_i = t.req; release_i = t.rel; en_i = t.en; rd_wr_i = t.rdwr; wdata_en_i = t.wen;
    dram_ready_i = t.rdy; dram_wdata_ready_i = t.wrdy; dram_rd_valid_i = t.rv;
    exp_q.push_back(t);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".permit"}, 64'(permit_o), 64'(e.e_permit));
      chk({name, ".dram_en"}, 64'(dram_en_o), 64'(e.e_en));
      chk({name, ".dram_wdata_en"}, 64'(dram_wdata_en_o), 64'(e.e_wen));
      chk({name, ".dram_addr"}, 64'(dram_addr_o), 64'(e.e_addr));
      chk({name, ".cmd_ready"}, 64'(cmd_ready_o), 64'(e.e_cmdrdy));
      chk({name, ".wdata_ready"}, 64'(wdata_ready_o), 64'(e.e_wrdy));
      chk({name, ".rd_valid"}, 64'(rd_valid_o), 64'(e.e_rv));
    end
    @(posedge clk); #1;
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  task automatic do_reset(input string name);
    zero_inputs();
    reset = 1'b0;
    #2;
    chk_all_zero(name);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    addr_i = {A3, A2, A1, A0};
    wdata_i = {NP*DW/32{32'hA5A5_5A5A}};
    mask_i = '0;
    zero_inputs();
    reset = 1'b0;
    #3;
    chk_all_zero("por");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // single requester, read on port 0, isolation of port 2, drain of 2 beats, grant to port 2
    tbl.push_back(vz(4'b0001));
    tbl.push_back(v(4'b0001, 4'b0, 4'b0001, 4'b0001, 4'b0, 1, 0, 0, 4'b0001, 1, 0, A0, 4'b0001, 4'b0, 4'b0));
    tbl.push_back(v(4'b0101, 4'b0, 4'b0100, 4'b0, 4'b0100, 1, 1, 0, 4'b0001, 0, 0, A0, 4'b0001, 4'b0001, 4'b0));
    tbl.push_back(v(4'b0100, 4'b0001, 4'b0, 4'b0, 4'b0, 0, 0, 1, 4'b0001, 0, 0, A0, 4'b0, 4'b0, 4'b0001));
    tbl.push_back(v(4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 1, 4'b0, 0, 0, '0, 4'b0, 4'b0, 4'b0001));
    tbl.push_back(vz(4'b0100));
    tbl.push_back(v(4'b0100, 4'b0, 4'b0100, 4'b0, 4'b0, 1, 0, 0, 4'b0100, 1, 0, A2, 4'b0100, 4'b0, 4'b0));
    tbl.push_back(v(4'b0, 4'b0100, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0100, 0, 0, A2, 4'b0, 4'b0, 4'b0));
    tbl.push_back(vz(4'b0));
    tbl.push_back(vz(4'b0));
    tbl.push_back(vz(4'b0));
    run_tbl("single");

    // round robin with req 1011 held: order 0,1,3,0; non-owner releases ignored
    do_reset("rst_rr");
    tbl.push_back(v(4'b1011, 4'b0001, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0, 0, 0, '0, 4'b0, 4'b0, 4'b0));
    tbl.push_back(v(4'b1011, 4'b0, 4'b1011, 4'b0, 4'b0, 1, 0, 0, 4'b0001, 1, 0, A0, 4'b0001, 4'b0, 4'b0));
    tbl.push_back(v(4'b1011, 4'b1011, 4'b0, 4'b0, 4'b0, 1, 0, 0, 4'b0001, 0, 0, A0, 4'b0001, 4'b0, 4'b0));
    tbl.push_back(vz(4'b1011));
    tbl.push_back(vz(4'b1011));
    tbl.push_back(v(4'b1011, 4'b0100, 4'b1011, 4'b0, 4'b0, 1, 0, 0, 4'b0010, 1, 0, A1, 4'b0010, 4'b0, 4'b0));
    tbl.push_back(v(4'b1011, 4'b0010, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0010, 0, 0, A1, 4'b0, 4'b0, 4'b0));
    tbl.push_back(vz(4'b1011));
    tbl.push_back(vz(4'b1011));
    tbl.push_back(v(4'b1011, 4'b0, 4'b1011, 4'b0, 4'b0, 1, 0, 0, 4'b1000, 1, 0, A3, 4'b1000, 4'b0, 4'b0));
    tbl.push_back(v(4'b1011, 4'b1000, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b1000, 0, 0, A3, 4'b0, 4'b0, 4'b0));
    tbl.push_back(vz(4'b1011));
    tbl.push_back(vz(4'b1011));
    tbl.push_back(v(4'b1011, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0001, 0, 0, A0, 4'b0, 4'b0, 4'b0));
    tbl.push_back(v(4'b0, 4'b0001, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0001, 0, 0, A0, 4'b0, 4'b0, 4'b0));
    tbl.push_back(vz(4'b0));
    tbl.push_back(vz(4'b0));
    run_tbl("rr");

    // drain: port 1 issues 3 reads, releases, 6 beats return; port 2 granted 2 cycles after the last
    do_reset("rst_drain");
    tbl.push_back(vz(4'b0010));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(4'b0010, 4'b0, 4'b0010, 4'b0010, 4'b0, 1, 0, 0, 4'b0010, 1, 0, A1, 4'b0010, 4'b0, 4'b0));
    tbl.push_back(v(4'b0110, 4'b0010, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0010, 0, 0, A1, 4'b0, 4'b0, 4'b0));
    tbl.push_back(v(4'b0100, 4'b0, 4'b0010, 4'b0010, 4'b0, 1, 0, 0, 4'b0, 0, 0, '0, 4'b0, 4'b0, 4'b0));
    tbl.push_back(vz(4'b0100));
    for (int i = 0; i < 7; i++) begin
      if (i == 2) tbl.push_back(vz(4'b0100));
      else tbl.push_back(v(4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 1, 4'b0, 0, 0, '0, 4'b0, 4'b0, 4'b0010));
    end
    tbl.push_back(vz(4'b0100));
    tbl.push_back(v(4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0100, 0, 0, A2, 4'b0, 4'b0, 4'b0));
    run_tbl("drain");

    // read accept and beat on the same cycle with one beat outstanding, then underflow beat
    do_reset("rst_simul");
    tbl.push_back(vz(4'b0001));
    tbl.push_back(v(4'b0001, 4'b0, 4'b0001, 4'b0001, 4'b0, 1, 0, 0, 4'b0001, 1, 0, A0, 4'b0001, 4'b0, 4'b0));
    tbl.push_back(v(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 1, 4'b0001, 0, 0, A0, 4'b0, 4'b0, 4'b0001));
    tbl.push_back(v(4'b0001, 4'b0, 4'b0001, 4'b0001, 4'b0, 1, 0, 1, 4'b0001, 1, 0, A0, 4'b0001, 4'b0, 4'b0001));
    tbl.push_back(v(4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0001, 0, 0, A0, 4'b0, 4'b0, 4'b0));
    tbl.push_back(v(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 1, 4'b0, 0, 0, '0, 4'b0, 4'b0, 4'b0001));
    tbl.push_back(v(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 1, 4'b0, 0, 0, '0, 4'b0, 4'b0, 4'b0001));
    tbl.push_back(vz(4'b0001));
    tbl.push_back(v(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0001, 0, 0, A0, 4'b0, 4'b0, 4'b0));
    tbl.push_back(v(4'b0, 4'b0001, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0001, 0, 0, A0, 4'b0, 4'b0, 4'b0));
    tbl.push_back(v(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 1, 4'b0, 0, 0, '0, 4'b0, 4'b0, 4'b0001));
    tbl.push_back(vz(4'b0));
    tbl.push_back(vz(4'b0));
    run_tbl("simul");

    // reset mid-tenure with 4 beats outstanding
    do_reset("rst_mid");
    tbl.push_back(vz(4'b0001));
    for (int i = 0; i < 2; i++)
      tbl.push_back(v(4'b0001, 4'b0, 4'b0001, 4'b0001, 4'b0, 1, 0, 0, 4'b0001, 1, 0, A0, 4'b0001, 4'b0, 4'b0));
    run_tbl("mid");
    req_i = 4'b0001; en_i = 4'b0001; rd_wr_i = 4'b0001; dram_ready_i = 1'b1; dram_wdata_ready_i = 1'b1;
    #1;
    chk("mid_pre.permit", 64'(permit_o), 64'(4'b0001));
    chk("mid_pre.dram_en", 64'(dram_en_o), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("mid_async");
    @(posedge clk); #1;
    zero_inputs();
    reset = 1'b1;
    tbl.push_back(vz(4'b0100));
    tbl.push_back(v(4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0100, 0, 0, A2, 4'b0, 4'b0, 4'b0));
    tbl.push_back(v(4'b0, 4'b0100, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0100, 0, 0, A2, 4'b0, 4'b0, 4'b0));
    tbl.push_back(vz(4'b0001));
    tbl.push_back(vz(4'b0001));
    tbl.push_back(v(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 4'b0001, 0, 0, A0, 4'b0, 4'b0, 4'b0));
    run_tbl("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
